// File: rtl/aes_unload_pkg.sv
// Shared types and defaults for the AES output unloader slice.
// Optional feature macro: AES_UNLOADER_PARITY_EN (adds out_parity output).
package aes_unload_pkg;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } unload_state_e;

    // Word index width: clog2 of the word count, never narrower than one bit.
    function automatic int idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/aes_word_shifter.sv
// Shift register and word index for serialising a cipher block, most
// significant word first. The presented word and last flag are registered.
// Optional feature macro: AES_UNLOADER_PARITY_EN (registered word parity).
module aes_word_shifter
    import aes_unload_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  last
`ifdef AES_UNLOADER_PARITY_EN
    ,
    output logic                  parity
`endif
);

    localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int IDX_W     = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] data_next_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_next_s;
    logic [WORD_WIDTH-1:0] word_r;
    logic [WORD_WIDTH-1:0] word_next_s;
    logic                  last_r;
    logic                  last_next_s;

    // Even parity of a word (XOR reduction).
    function automatic logic word_parity(input logic [WORD_WIDTH-1:0] w);
        return ^w;
    endfunction

    assign shifted_s = data_r << WORD_WIDTH;

    // Next-state of the shifter: load a block, step to the next word, or hold.
    always_comb begin
        data_next_s = data_r;
        idx_next_s  = idx_r;
        word_next_s = word_r;
        last_next_s = last_r;
        if (load) begin
            data_next_s = data_in;
            idx_next_s  = '0;
            word_next_s = data_in[DATA_WIDTH-1 -: WORD_WIDTH];
            last_next_s = (LAST_IDX == '0);
        end else if (advance) begin
            if (idx_r != LAST_IDX) begin
                data_next_s = shifted_s;
                idx_next_s  = idx_r + IDX_W'(1);
                word_next_s = shifted_s[DATA_WIDTH-1 -: WORD_WIDTH];
                last_next_s = ((idx_r + IDX_W'(1)) == LAST_IDX);
            end else begin
                // Final word consumed: index parks at the top, outputs go quiet.
                word_next_s = '0;
                last_next_s = 1'b0;
            end
        end else begin
            data_next_s = data_r;
            idx_next_s  = idx_r;
        end
    end

    // Shifter state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            data_r <= '0;
            idx_r  <= '0;
            word_r <= '0;
            last_r <= 1'b0;
        end else begin
            data_r <= data_next_s;
            idx_r  <= idx_next_s;
            word_r <= word_next_s;
            last_r <= last_next_s;
        end
    end

`ifdef AES_UNLOADER_PARITY_EN
    logic parity_r;

    // Parity registered alongside the word it describes.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= word_parity(word_next_s);
        end
    end

    assign parity = parity_r;
`endif

    assign word = word_r;
    assign last = last_r;

endmodule

// File: rtl/aes_output_unloader.sv
// Waits for the 40-stage AES pipeline to finish a block, captures it and
// streams it out word by word over a valid/ready handshake.
// Optional feature macro: AES_UNLOADER_PARITY_EN (adds out_parity output).
module aes_output_unloader
    import aes_unload_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  done_flag,
    input  logic [DATA_WIDTH-1:0] cipher_in,
    output logic                  count_enable,
    output logic [WORD_WIDTH-1:0] out_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
`ifdef AES_UNLOADER_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    unload_state_e state_r;
    unload_state_e state_next_s;
    logic          load_s;
    logic          advance_s;
    logic          count_enable_r;
    logic          out_valid_r;
    logic          busy_r;

    // Next-state logic; a transfer in SEND is simply out_ready since out_valid is 1 there.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (done_flag) begin
                    state_next_s = SEND;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = WAIT;
                end
            end
            SEND: begin
                if (out_ready) begin
                    advance_s = 1'b1;
                    if (out_last) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = SEND;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and Moore outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r        <= IDLE;
            count_enable_r <= 1'b0;
            out_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            count_enable_r <= (state_next_s == WAIT);
            out_valid_r    <= (state_next_s == SEND);
            busy_r         <= (state_next_s != IDLE);
        end
    end

    aes_word_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_shifter (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (load_s),
        .advance (advance_s),
        .data_in (cipher_in),
        .word    (out_word),
        .last    (out_last)
`ifdef AES_UNLOADER_PARITY_EN
        ,
        .parity  (out_parity)
`endif
    );

    assign count_enable = count_enable_r;
    assign out_valid    = out_valid_r;
    assign busy         = busy_r;

endmodule
